// File: rtl/axi_lite_accel_csr.sv
// axi_lite_accel_csr: AXI-Lite CSR block for the matrix accelerator.
// It holds the job CFG registers and a START snapshot queue, and it launches jobs back to back.
// It also keeps a sticky DONE flag and a cycle count for each job.
// Define ACCEL_CSR_IRQ_EN to add the irq port and the IRQ_EN register at 0x08.
module axi_lite_accel_csr #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int NUM_CFG   = 4,
  parameter int CMD_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_W-1:0]         s_axi_wdata,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic                      s_axi_bvalid,
  output logic [1:0]                s_axi_bresp,
  input  logic                      s_axi_bready,
  input  logic [ADDR_W-1:0]         s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic                      s_axi_rvalid,
  output logic [DATA_W-1:0]         s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  input  logic                      s_axi_rready,
  output logic [NUM_CFG*DATA_W-1:0] core_cfg,
  output logic                      core_start,
  input  logic                      core_done
`ifdef ACCEL_CSR_IRQ_EN
  ,
  output logic                      irq
`endif
);
  localparam int QW = $clog2(CMD_DEPTH);
  localparam int CW = NUM_CFG * DATA_W;
`ifdef ACCEL_CSR_IRQ_EN
  localparam logic HAS_IRQ = 1'b1;
  logic irq_en;
`else
  localparam logic HAS_IRQ = 1'b0;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic aw_held, w_held, done;
  logic [7:0] aw_off, ar_off;
  logic [DATA_W-1:0] w_data, status, rd_val;
  logic [NUM_CFG-1:0][DATA_W-1:0] cfg;
  logic [CW-1:0] queue [CMD_DEPTH];
  logic [QW:0] wptr, rptr, count;
  logic [CNT_W-1:0] cnt, cnt_inc, cycles;
  logic full, empty, commit, wr_err, wr_ok, push, pop, rd_err;
  logic unused_addr;

  function automatic logic is_cfg(input logic [7:0] a);
    return a[1:0] == 2'b00 && a >= 8'h10 && {1'b0, a} < 9'(16 + 4 * NUM_CFG);
  endfunction

  function automatic logic is_mapped(input logic [7:0] a);
    return a == 8'h00 || a == 8'h04 || (HAS_IRQ && a == 8'h08) || a == 8'h0C || is_cfg(a);
  endfunction

  assign unused_addr   = ^{s_axi_awaddr[ADDR_W-1:8], s_axi_araddr[ADDR_W-1:8]};
  assign ar_off        = s_axi_araddr[7:0];
  assign s_axi_awready = !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = !w_held && !s_axi_bvalid;
  assign s_axi_arready = !s_axi_rvalid;
  assign count         = wptr - rptr;
  assign full          = count == (QW+1)'(CMD_DEPTH);
  assign empty         = count == '0;
  assign commit        = aw_held && w_held && !s_axi_bvalid;
  assign wr_err        = !is_mapped(aw_off) || aw_off == 8'h0C || (aw_off == 8'h00 && w_data[0] && full);
  assign wr_ok         = commit && !wr_err;
  assign push          = wr_ok && aw_off == 8'h00 && w_data[0];
  assign pop           = state == IDLE && !empty;
  assign cnt_inc       = &cnt ? cnt : cnt + CNT_W'(1);
  assign status        = DATA_W'({8'(count), 4'b0, empty, full, state == RUN, done});
  assign rd_err        = !is_mapped(ar_off);

  // Read mux; misaligned and unmapped offsets fall through to zero
  always_comb begin
    rd_val = ar_off == 8'h04 ? status : ar_off == 8'h0C ? DATA_W'(cycles) : '0;
`ifdef ACCEL_CSR_IRQ_EN
    rd_val = ar_off == 8'h08 ? DATA_W'(irq_en) : rd_val;
`endif
    for (int i = 0; i < NUM_CFG; i++) rd_val = ar_off == 8'(16 + 4 * i) ? cfg[i] : rd_val;
  end

  // Write channel: independent AW/W buffers, commit one cycle after both are full, release on B handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_off       <= '0;
      w_data       <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_off  <= s_axi_awaddr[7:0];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
      end
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err ? 2'b10 : 2'b00;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end
    end
  end

  // Read channel: data and response registered at the AR handshake, held until rready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= 2'b00;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_val;
      s_axi_rresp  <= rd_err ? 2'b10 : 2'b00;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  // Host-visible registers; a DONE set from the core beats a same-cycle W1C
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg  <= '0;
      done <= 1'b0;
`ifdef ACCEL_CSR_IRQ_EN
      irq_en <= 1'b0;
      irq    <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < NUM_CFG; i++) if (wr_ok && aw_off == 8'(16 + 4 * i)) cfg[i] <= w_data;
      done <= (state == RUN && core_done) || (done && !(wr_ok && aw_off == 8'h04 && w_data[0]));
`ifdef ACCEL_CSR_IRQ_EN
      if (wr_ok && aw_off == 8'h08) irq_en <= w_data[0];
      irq <= irq_en && done;
`endif
    end
  end

  // Each accepted START snapshots the CFG registers as they stand in the commit cycle
  always_ff @(posedge clk) if (push) queue[wptr[QW-1:0]] <= cfg;

  // Launch FSM: pop and pulse core_start from IDLE, then count RUN cycles until core_done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      core_cfg   <= '0;
      core_start <= 1'b0;
      cnt        <= '0;
      cycles     <= '0;
    end else begin
      core_start <= pop;
      if (push) wptr <= wptr + (QW+1)'(1);
      if (pop) begin
        rptr     <= rptr + (QW+1)'(1);
        core_cfg <= queue[rptr[QW-1:0]];
        cnt      <= '0;
        state    <= RUN;
      end
      if (state == RUN) begin
        cnt <= cnt_inc;
        if (core_done) begin
          cycles <= cnt_inc;
          state  <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_accel_csr.sv
// tb_axi_lite_accel_csr: directed bench for the accelerator CSR block.
// It covers the AXI-Lite protocol, the START queue, the cycle counter and the error responses.
// Under ACCEL_CSR_IRQ_EN it also checks irq.
module tb_axi_lite_accel_csr;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0;
  logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
  logic s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;
  logic [127:0] core_cfg;
  logic core_start;
  logic core_done = 1'b0;
`ifdef ACCEL_CSR_IRQ_EN
  logic irq;
`endif

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int done_delay = 0;
  int left = 0;
  bit done_now = 1'b0;
  logic [31:0] cfg_log [16];

  axi_lite_accel_csr dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bresp(s_axi_bresp), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rready(s_axi_rready),
    .core_cfg(core_cfg), .core_start(core_start), .core_done(core_done)
`ifdef ACCEL_CSR_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Core model: logs each launch and pulses core_done so the job lasts done_delay cycles
  // counting the start cycle (done_delay 0 stalls); done_now forces a pulse
  initial forever begin
    @(negedge clk);
    core_done = 1'b0;
    if (core_start) begin
      if (starts < 16) cfg_log[starts] = core_cfg[31:0];
      starts++;
      left = done_delay;
    end
    if (left > 0) begin
      left--;
      if (left == 0) core_done = 1'b1;
    end
    if (done_now) begin
      core_done = 1'b1;
      done_now = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input int lead, output logic [1:0] resp);
    bit aw_ok, w_ok;
    int t;
    aw_ok = 1'b0;
    w_ok = 1'b0;
    t = 0;
    resp = 2'b11;
    while (!(aw_ok && w_ok) && t < 50) begin
      @(negedge clk);
      s_axi_awaddr = 32'(a);
      s_axi_wdata = d;
      s_axi_awvalid = !aw_ok && t >= lead;
      s_axi_wvalid = !w_ok;
      #1;
      if (s_axi_awvalid && s_axi_awready) aw_ok = 1'b1;
      if (s_axi_wvalid && s_axi_wready) w_ok = 1'b1;
      t++;
    end
    if (t >= 50) check("wr_addr_data_timeout", 32'(t), 0);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("wr_b_timeout", 32'(t), 0);
    resp = s_axi_bresp;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int t;
    t = 0;
    @(negedge clk);
    s_axi_araddr = 32'(a);
    s_axi_arvalid = 1'b1;
    #1;
    while (!s_axi_arready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    while (!s_axi_rvalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("rd_timeout", 32'(t), 0);
    d = s_axi_rdata;
    resp = s_axi_rresp;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] a, input logic [31:0] d, input int lead,
                        input logic [1:0] exp);
    logic [1:0] r;
    wr(a, d, lead, r);
    check(tag, 32'(r), 32'(exp));
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                        input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0] r;
    rd(a, d, r);
    check(tag, d, exp_d);
    check({tag, "_resp"}, 32'(r), 32'(exp_r));
  endtask

  initial begin
    int t;
    logic [31:0] d;
    logic [1:0] r;
    repeat (3) @(negedge clk);
    check("rst_core_start", 32'(core_start), 0);
    check("rst_core_cfg", core_cfg[31:0], 0);
    check("rst_bvalid", 32'(s_axi_bvalid), 0);
    check("rst_rvalid", 32'(s_axi_rvalid), 0);
    rst_n = 1'b1;
    rd_chk("rst_status", 8'h04, 32'h0000_0008, OKAY);
    rd_chk("rst_cfg0", 8'h10, 32'h0, OKAY);
    rd_chk("rst_unmapped", 8'h40, 32'h0, SLVERR);

    wr_chk("w_first", 8'h10, 32'h5, 3, OKAY);
    check("b_single", 32'(s_axi_bvalid), 0);
    rd_chk("w_first_rb", 8'h10, 32'h5, OKAY);
    wr_chk("aw_w_same", 8'h14, 32'hA5A5, 0, OKAY);
    rd_chk("aw_w_same_rb", 8'h14, 32'hA5A5, OKAY);
    rd_chk("ctrl_reads_0", 8'h00, 32'h0, OKAY);

    done_delay = 10;
    wr_chk("cfg0_7", 8'h10, 32'h7, 0, OKAY);
    wr_chk("start_a", 8'h00, 32'h1, 0, OKAY);
    wr_chk("cfg0_9", 8'h10, 32'h9, 0, OKAY);
    wr_chk("start_b", 8'h00, 32'h1, 0, OKAY);
    repeat (40) @(negedge clk);
    check("starts_two", 32'(starts), 2);
    check("job1_cfg", cfg_log[0], 32'h7);
    check("job2_cfg", cfg_log[1], 32'h9);
    rd_chk("cycles_10", 8'h0C, 32'd10, OKAY);
    rd_chk("status_done", 8'h04, 32'h0000_0009, OKAY);

    done_delay = 0;
    for (int i = 0; i < 5; i++) wr_chk($sformatf("start_q%0d", i), 8'h00, 32'h1, 0, OKAY);
    wr_chk("start_full", 8'h00, 32'h1, 0, SLVERR);
    rd_chk("status_full", 8'h04, 32'h0000_0407, OKAY);

    wr_chk("wr_cycles", 8'h0C, 32'h123, 0, SLVERR);
    rd_chk("cycles_kept", 8'h0C, 32'd10, OKAY);
    wr_chk("wr_misalign", 8'h11, 32'h1, 0, SLVERR);
    wr_chk("w1c_done", 8'h04, 32'h1, 0, OKAY);
    rd_chk("status_cleared", 8'h04, 32'h0000_0406, OKAY);

    @(negedge clk);
    s_axi_awaddr = 32'h4;
    s_axi_wdata = 32'h1;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1;
    @(posedge clk);
    #1 done_now = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    @(negedge clk);
    check("w1c_race_bvalid", 32'(s_axi_bvalid), 1);
    check("w1c_race_bresp", 32'(s_axi_bresp), 32'(OKAY));
    @(negedge clk);
    s_axi_bready = 1'b0;
    repeat (3) @(negedge clk);
    rd_chk("set_wins", 8'h04, 32'h0000_0303, OKAY);

    done_delay = 3;
    done_now = 1'b1;
    repeat (40) @(negedge clk);
    check("starts_drained", 32'(starts), 7);
    rd_chk("status_drained", 8'h04, 32'h0000_0009, OKAY);

`ifdef ACCEL_CSR_IRQ_EN
    wr_chk("irq_en_wr", 8'h08, 32'h1, 0, OKAY);
    rd_chk("irq_en_rb", 8'h08, 32'h1, OKAY);
    wr_chk("irq_w1c", 8'h04, 32'h1, 0, OKAY);
    repeat (2) @(negedge clk);
    check("irq_idle", 32'(irq), 0);
    done_delay = 5;
    wr_chk("irq_start", 8'h00, 32'h1, 0, OKAY);
    t = 0;
    while (!core_done && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 100) check("irq_done_timeout", 32'(t), 0);
    @(negedge clk);
    #1 check("irq_lag", 32'(irq), 0);
    @(negedge clk);
    #1 check("irq_set", 32'(irq), 1);
    wr_chk("irq_clear_wr", 8'h04, 32'h1, 0, OKAY);
    repeat (2) @(negedge clk);
    check("irq_cleared", 32'(irq), 0);
`else
    rd_chk("irq_en_unmapped", 8'h08, 32'h0, SLVERR);
    wr_chk("irq_en_wr_err", 8'h08, 32'h1, 0, SLVERR);
`endif

    done_delay = 0;
    wr_chk("rst_start_a", 8'h00, 32'h1, 0, OKAY);
    wr_chk("rst_start_b", 8'h00, 32'h1, 0, OKAY);
    rd(8'h04, d, r);
    check("busy_before_rst", d & 32'h0000_FF0E, 32'h0000_0102);
    check("cfg_before_rst", core_cfg[31:0], 32'h9);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun_core_start", 32'(core_start), 0);
    check("midrun_core_cfg", core_cfg[31:0], 0);
`ifdef ACCEL_CSR_IRQ_EN
    check("midrun_irq", 32'(irq), 0);
`endif
    rst_n = 1'b1;
    rd_chk("midrun_status", 8'h04, 32'h0000_0008, OKAY);
    rd_chk("midrun_cfg0", 8'h10, 32'h0, OKAY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
